// File: rtl/unidade_busca_pkg.sv
// Shared definitions for the instruction fetch unit.
//   - word width, PC increment, default reset PC and the NOP encoding
//   - payload struct for the output register and the output-register state enum
package pacote_busca;

  localparam int unsigned LARGURA_PALAVRA = 32;

  localparam logic [LARGURA_PALAVRA-1:0] INCREMENTO_PC   = 32'd4;
  localparam logic [LARGURA_PALAVRA-1:0] PC_RESET_PADRAO = 32'h0000_0000;
  localparam logic [LARGURA_PALAVRA-1:0] NOP             = 32'h0000_0000;

  typedef logic [LARGURA_PALAVRA-1:0] palavra_t;

  // Contents of the output register handed to decode
  typedef struct packed {
    palavra_t instrucao;
    palavra_t pc;
    palavra_t pc_mais4;
  } carga_saida_t;

  // Occupancy of the output register
  typedef enum logic {
    VAZIO = 1'b0,
    CHEIO = 1'b1
  } estado_t;

endpackage

// File: rtl/unidade_busca_if.sv
// Bus bundle of the fetch unit: instruction memory read port, redirect input,
// decode-side valid/ready handshake and status outputs.
//   master: the fetch unit (drives addr, saida_*, erro_alinhamento, contador_busca)
//   slave : memory / redirect logic / decode side
interface unidade_busca_if;
  import pacote_busca::*;

  palavra_t addr;
  palavra_t instrucao;
  logic     desvio_valido;
  palavra_t desvio_alvo;
  logic     saida_valida;
  logic     saida_pronta;
  palavra_t saida_instrucao;
  palavra_t saida_pc;
  palavra_t saida_pc_mais4;
  logic     erro_alinhamento;
  palavra_t contador_busca;

  modport master (
    output addr,
    input  instrucao,
    input  desvio_valido,
    input  desvio_alvo,
    output saida_valida,
    input  saida_pronta,
    output saida_instrucao,
    output saida_pc,
    output saida_pc_mais4,
    output erro_alinhamento,
    output contador_busca
  );

  modport slave (
    input  addr,
    output instrucao,
    output desvio_valido,
    output desvio_alvo,
    input  saida_valida,
    output saida_pronta,
    input  saida_instrucao,
    input  saida_pc,
    input  saida_pc_mais4,
    input  erro_alinhamento,
    input  contador_busca
  );

endinterface

// File: rtl/unidade_busca_registrador_pc.sv
// Program counter register.
//   clk, reset      : clock, synchronous active-high reset
//   valor_reset     : PC loaded on reset
//   carrega_desvio  : load alvo (takes priority over incrementa)
//   alvo            : already word-aligned redirect target
//   incrementa      : advance PC by one word (wraps modulo 2^32)
//   pc              : current PC
module registrador_pc
  import pacote_busca::*;
(
  input  logic     clk,
  input  logic     reset,
  input  palavra_t valor_reset,
  input  logic     carrega_desvio,
  input  palavra_t alvo,
  input  logic     incrementa,
  output palavra_t pc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= valor_reset;
    end else if (carrega_desvio) begin
      pc <= alvo;
    end else if (incrementa) begin
      pc <= pc + INCREMENTO_PC;
    end
  end

endmodule

// File: rtl/unidade_busca.sv
// Instruction fetch unit: drives the PC as the instruction memory address,
// captures the returned word into an output register and hands it to decode
// over a valid/ready handshake. Redirects flush the buffered word.
//   clk, reset : clock, synchronous active-high reset
//   bus        : unidade_busca_if.master (memory port, redirect, decode handshake,
//                alignment error flag, accepted-instruction counter)
module unidade_busca
  import pacote_busca::*;
#(
  parameter logic [LARGURA_PALAVRA-1:0] PC_INICIAL = PC_RESET_PADRAO
) (
  input  logic            clk,
  input  logic            reset,
  unidade_busca_if.master bus
);

  palavra_t     pc;
  estado_t      estado;
  estado_t      proximo_estado;
  carga_saida_t saida_q;
  palavra_t     contador_q;
  logic         erro_q;

  logic         transfere_c;
  logic         busca_c;
  logic         desalinhado_c;
  palavra_t     alvo_alinhado_c;

  // Handshake and fetch-enable decode
  assign transfere_c     = (estado == CHEIO) && bus.saida_pronta;
  assign busca_c         = !bus.desvio_valido && ((estado == VAZIO) || bus.saida_pronta);
  assign desalinhado_c   = bus.desvio_valido && (bus.desvio_alvo[1:0] != 2'b00);
  assign alvo_alinhado_c = {bus.desvio_alvo[LARGURA_PALAVRA-1:2], 2'b00};

  registrador_pc u_registrador_pc (
    .clk            (clk),
    .reset          (reset),
    .valor_reset    (PC_INICIAL),
    .carrega_desvio (bus.desvio_valido),
    .alvo           (alvo_alinhado_c),
    .incrementa     (busca_c),
    .pc             (pc)
  );

  // Output-register occupancy state
  always_ff @(posedge clk) begin
    if (reset) begin
      estado <= VAZIO;
    end else begin
      estado <= proximo_estado;
    end
  end

  // Redirect flushes; otherwise a fetch fills the register
  always_comb begin
    proximo_estado = estado;
    if (bus.desvio_valido) begin
      proximo_estado = VAZIO;
    end else if (busca_c) begin
      proximo_estado = CHEIO;
    end
  end

  // Output payload; pc_mais4 is registered alongside pc so it is never a comb path
  always_ff @(posedge clk) begin
    if (reset) begin
      saida_q.instrucao <= NOP;
      saida_q.pc        <= '0;
      saida_q.pc_mais4  <= INCREMENTO_PC;
    end else if (busca_c) begin
      saida_q.instrucao <= bus.instrucao;
      saida_q.pc        <= pc;
      saida_q.pc_mais4  <= pc + INCREMENTO_PC;
    end
  end

  // Accepted-instruction counter; a handshake completing alongside a redirect still counts
  always_ff @(posedge clk) begin
    if (reset) begin
      contador_q <= '0;
    end else if (transfere_c) begin
      contador_q <= contador_q + 32'd1;
    end
  end

  // Sticky misaligned-target flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      erro_q <= 1'b0;
    end else if (desalinhado_c) begin
      erro_q <= 1'b1;
    end
  end

  assign bus.addr             = pc;
  assign bus.saida_valida     = (estado == CHEIO);
  assign bus.saida_instrucao  = saida_q.instrucao;
  assign bus.saida_pc         = saida_q.pc;
  assign bus.saida_pc_mais4   = saida_q.pc_mais4;
  assign bus.erro_alinhamento = erro_q;
  assign bus.contador_busca   = contador_q;

endmodule

// File: tb/tb_unidade_busca.sv
// Self-checking bench for unidade_busca: directed scenarios followed by random
// traffic, all compared against a cycle-level reference model of the fetch rules.
module tb_unidade_busca;

  logic clk;
  logic rst;
  logic rst1;

  unidade_busca_if b0 ();
  unidade_busca_if b1 ();

  logic [31:0] mem [256];

  unidade_busca dut0 (
    .clk   (clk),
    .reset (rst),
    .bus   (b0)
  );

  unidade_busca #(.PC_INICIAL(32'hFFFF_FFFC)) dut1 (
    .clk   (clk),
    .reset (rst1),
    .bus   (b1)
  );

  // Combinational instruction memory, word-indexed by addr[9:2]
  assign b0.instrucao = mem[b0.addr[9:2]];
  assign b1.instrucao = mem[b1.addr[9:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_spc;
  logic        m_err;
  logic [31:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge of the fetch rules, using the inputs held before the edge
  task automatic modelo();
    logic transfer;
    if (rst) begin
      m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0; m_spc = 32'h0;
      m_err = 1'b0; m_cnt = 32'h0;
    end else begin
      transfer = m_valid && b0.saida_pronta;
      if (transfer) m_cnt = m_cnt + 32'd1;
      if (b0.desvio_valido) begin
        m_pc    = b0.desvio_alvo & 32'hFFFF_FFFC;
        m_valid = 1'b0;
        if (b0.desvio_alvo[1:0] != 2'b00) m_err = 1'b1;
      end else if (!m_valid || b0.saida_pronta) begin
        m_instr = mem[m_pc[9:2]];
        m_spc   = m_pc;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
      end
    end
  endtask

  task automatic compara();
    chk("addr",       b0.addr,                     m_pc);
    chk("valida",     32'(b0.saida_valida),        32'(m_valid));
    chk("instrucao",  b0.saida_instrucao,          m_instr);
    chk("saida_pc",   b0.saida_pc,                 m_spc);
    chk("pc_mais4",   b0.saida_pc_mais4,           m_spc + 32'd4);
    chk("erro",       32'(b0.erro_alinhamento),    32'(m_err));
    chk("contador",   b0.contador_busca,           m_cnt);
  endtask

  task automatic step();
    @(posedge clk);
    modelo();
    #1;
    compara();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h2008_0001;
    mem[1] = 32'h2009_0002;
    mem[2] = 32'h0109_5020;
    mem[3] = 32'hAC0A_0000;

    m_pc = 0; m_valid = 0; m_instr = 0; m_spc = 0; m_err = 0; m_cnt = 0;
    rst = 1'b1; rst1 = 1'b1;
    b0.desvio_valido = 1'b0; b0.desvio_alvo = 32'h0; b0.saida_pronta = 1'b0;
    b1.desvio_valido = 1'b0; b1.desvio_alvo = 32'h0; b1.saida_pronta = 1'b1;

    // Reset state of both instances
    step();
    chk("rst_valida",   32'(b0.saida_valida), 32'h0);
    chk("rst_mais4",    b0.saida_pc_mais4,    32'h4);
    chk("top_rst_addr", b1.addr,              32'hFFFF_FFFC);

    // Top-of-memory start: wrap of PC and pc_mais4
    rst1 = 1'b0;
    step();
    chk("top_valida", 32'(b1.saida_valida), 32'h1);
    chk("top_pc",     b1.saida_pc,          32'hFFFF_FFFC);
    chk("top_mais4",  b1.saida_pc_mais4,    32'h0);
    chk("top_instr",  b1.saida_instrucao,   mem[255]);
    step();
    chk("top_pc2",    b1.saida_pc,          32'h0);
    chk("top_instr2", b1.saida_instrucao,   mem[0]);

    // Streaming with decode always ready
    rst = 1'b0; b0.saida_pronta = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("stream_cnt", b0.contador_busca, 32'd4);

    // Back-pressure on the second word
    rst = 1'b1; step();
    rst = 1'b0; b0.saida_pronta = 1'b0; step();
    b0.saida_pronta = 1'b1; step();
    b0.saida_pronta = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("bp_instr", b0.saida_instrucao, 32'h2009_0002);
    chk("bp_pc",    b0.saida_pc,        32'h4);
    chk("bp_addr",  b0.addr,            32'h8);
    chk("bp_cnt",   b0.contador_busca,  32'd1);
    b0.saida_pronta = 1'b1; step();
    chk("bp_next",  b0.saida_instrucao, 32'h0109_5020);

    // Redirect while stalled: buffered word dropped, no count
    b0.saida_pronta = 1'b0; b0.desvio_valido = 1'b1; b0.desvio_alvo = 32'h8; step();
    chk("rd_valida", 32'(b0.saida_valida), 32'h0);
    chk("rd_addr",   b0.addr,              32'h8);
    b0.desvio_valido = 1'b0; step();
    chk("rd_instr",  b0.saida_instrucao,   32'h0109_5020);
    chk("rd_pc",     b0.saida_pc,          32'h8);

    // Redirect coinciding with a completed handshake still counts
    b0.saida_pronta = 1'b1; b0.desvio_valido = 1'b1; step();
    chk("rd_cnt",    b0.contador_busca,    32'd3);
    b0.desvio_valido = 1'b0; step();

    // Misaligned redirect sets a sticky flag
    b0.desvio_valido = 1'b1; b0.desvio_alvo = 32'h6; step();
    chk("mis_addr",  b0.addr,                     32'h4);
    chk("mis_erro",  32'(b0.erro_alinhamento),    32'h1);
    b0.desvio_alvo = 32'h10; step();
    b0.desvio_valido = 1'b0; step(); step();
    chk("mis_stick", 32'(b0.erro_alinhamento),    32'h1);
    rst = 1'b1; step();
    chk("mis_clr",   32'(b0.erro_alinhamento),    32'h0);

    // Reset together with a redirect mid-stream
    rst = 1'b0;
    for (int i = 0; i < 6; i++) step();
    rst = 1'b1; b0.desvio_valido = 1'b1; b0.desvio_alvo = 32'h40; step();
    chk("rr_valida", 32'(b0.saida_valida), 32'h0);
    chk("rr_addr",   b0.addr,              32'h0);
    chk("rr_cnt",    b0.contador_busca,    32'h0);
    rst = 1'b0; b0.desvio_valido = 1'b0;

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rst              = ($urandom_range(0, 149) == 0);
      b0.saida_pronta  = ($urandom_range(0, 3) != 0);
      b0.desvio_valido = ($urandom_range(0, 9) == 0);
      b0.desvio_alvo   = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h0000_03FC);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/unidade_busca.md
# unidade_busca

Instruction fetch unit: the reading side of `memoria_instrucoes`. It holds the program counter, drives the word address into the instruction memory, and captures the returned instruction into an output register. The output register feeds the decode stage over a valid/ready handshake. It sits between the PC-redirect logic (branch/jump resolution) and decode. Redirects flush the buffered instruction; back-pressure from decode stalls the fetch.

## Interface
- `PC_INICIAL`, default 32'h0000_0000: PC value loaded on reset.
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: synchronous, active-high.
- `addr`, output, 32: instruction memory address. Always equals the PC register. Combinational from the register only.
- `instrucao`, input, 32: memory read data. Combinational function of `addr`, valid in the same cycle.
- `desvio_valido`, input, 1: redirect request this cycle.
- `desvio_alvo`, input, 32: redirect target address.
- `saida_valida`, output, 1: the output register holds an instruction.
- `saida_pronta`, input, 1: decode accepts the instruction this cycle.
- `saida_instrucao`, output, 32: buffered instruction word.
- `saida_pc`, output, 32: address the buffered instruction was fetched from.
- `saida_pc_mais4`, output, 32: `saida_pc + 4`, computed modulo 2^32.
- `erro_alinhamento`, output, 1: sticky flag. Set when a redirect target has a non-zero `desvio_alvo[1:0]`.
- `contador_busca`, output, 32: count of instructions accepted by decode. Wraps modulo 2^32.

## Operation
- Reset values:
  - PC = `PC_INICIAL`.
  - `saida_valida` = 0.
  - `saida_instrucao`, `saida_pc` = 0, so `saida_pc_mais4` = 4.
  - `erro_alinhamento` = 0.
  - `contador_busca` = 0.
- Transfer: occurs when `saida_valida && saida_pronta`. Each transfer increments `contador_busca` by 1.
- Fetch fires when `!desvio_valido && (!saida_valida || saida_pronta)`. On a fire:
  - `saida_instrucao` <= `instrucao`.
  - `saida_pc` <= PC.
  - `saida_valida` <= 1.
  - PC <= PC + 4, wrapping 32'hFFFF_FFFC to 0.
- Redirect (`desvio_valido`=1) has priority over fetch:
  - PC <= {`desvio_alvo[31:2]`, 2'b00}.
  - `saida_valida` <= 0, flushing any buffered instruction.
  - No fetch occurs in that cycle.
  - If `desvio_alvo[1:0]` != 0, `erro_alinhamento` <= 1. It clears only on reset.
- Redirect during a transfer: if the transfer handshake completes in the same cycle as a redirect, the transfer counts. Decode has consumed the word and `contador_busca` increments.
- Stall: when `saida_valida && !saida_pronta && !desvio_valido`, all registers hold. `addr`, `saida_*` and the counter are stable.
- Address width: the memory uses only `addr[9:2]`. The PC itself is a full 32-bit register. Aliasing above 1 KiB is the memory's concern.
- Reset mid-operation overrides everything, including a concurrent redirect. Buffered instructions are lost.

## Timing
- Latency: 1 cycle from PC to `saida_valida`.
- After reset is deasserted at edge E, `saida_valida`=1 after edge E+1. It holds the word at `PC_INICIAL`.
- Throughput: 1 instruction/cycle while `saida_pronta`=1 and there are no redirects.
- Redirect sampled at edge N:
  - `addr` = target after edge N.
  - `saida_valida`=0 during cycle N→N+1.
  - The target instruction is valid after edge N+1.
  - Redirect bubble: exactly 1 cycle.
- `saida_valida` never drops without a transfer, a redirect or a reset.
- `saida_instrucao`/`saida_pc` never change while `saida_valida && !saida_pronta` unless a redirect occurs.

## Structure
- Shared package `pacote_busca` contains:
  - `LARGURA_PALAVRA` = 32.
  - `INCREMENTO_PC` = 4.
  - `PC_RESET_PADRAO` = 32'h0.
  - `NOP` = 32'h0000_0000.
- One sub-module, `registrador_pc`, holds the PC register:
  - Inputs: reset value, load-redirect, increment-enable.
  - Output: PC.
- The output register, handshake and counter stay in `unidade_busca`.

## Test plan
- Reset, then `saida_pronta`=1 with the memory image 20080001/20090002/01095020/AC0A0000:
  - Four consecutive transfers at `saida_pc` 0, 4, 8, C with those words.
  - `saida_pc_mais4` = 4, 8, C, 10.
  - `contador_busca`=4.
- Back-pressure: `saida_pronta`=0 for 3 cycles while valid.
  - `saida_instrucao`=20090002, `saida_pc`=4 and `addr`=8 are held.
  - The counter is unchanged.
  - On release, the next word is 01095020.
- Redirect to 32'h8 while valid and not ready:
  - The buffered word is dropped and valid drops for 1 cycle.
  - The next valid word is 01095020 at `saida_pc`=8.
  - Repeat with `saida_pronta`=1 in the redirect cycle: the counter increments.
- Misaligned redirect to 32'h6:
  - `addr`=4 and `erro_alinhamento`=1.
  - The flag persists across later aligned redirects and clears only on `reset`.
- With `PC_INICIAL`=32'hFFFF_FFFC:
  - The first word has `saida_pc`=FFFF_FFFC and `saida_pc_mais4`=0.
  - The next word has `saida_pc`=0.
- Reset asserted mid-stream together with a redirect:
  - Next cycle: `saida_valida`=0, `addr`=`PC_INICIAL`, counter=0.
